// File: rtl/div_if.sv
// Handshake bundle between the EX stage and the iterative divider.
// The master launches and flushes divisions; the slave reports stall, busy and the HI/LO result.
interface div_if #(
  parameter int WIDTH = 32
);
  logic               div_start;
  logic               div_signed;
  logic [WIDTH-1:0]   div_opa;
  logic [WIDTH-1:0]   div_opb;
  logic               div_cancel;
  logic               div_busy;
  logic               div_stallreq;
  logic               div_done;
  logic               div_hilowe;
  logic [2*WIDTH-1:0] div_res;

  modport master (
    output div_start, div_signed, div_opa, div_opb, div_cancel,
    input  div_busy, div_stallreq, div_done, div_hilowe, div_res
  );

  modport slave (
    input  div_start, div_signed, div_opa, div_opb, div_cancel,
    output div_busy, div_stallreq, div_done, div_hilowe, div_res
  );
endinterface

// File: rtl/div_seq.sv
// Radix-2 restoring divider sequencer: one quotient bit per cycle, stalls the pipeline while
// working and delivers {remainder, quotient} with a one-cycle HI/LO write-enable pulse.
module div_seq #(
  parameter int WIDTH = 32
) (
  input  logic cpu_clk_50M,
  input  logic cpu_rst,
  div_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DIVZERO = 2'd1,
    RUN     = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t             state_r;
  logic [CW-1:0]      cnt_r;
  logic [WIDTH-1:0]   rem_r;
  logic [WIDTH-1:0]   quo_r;
  logic [WIDTH-1:0]   dvs_r;
  logic               neg_q_r;
  logic               neg_r_r;
  logic               busy_r;
  logic               done_r;
  logic [2*WIDTH-1:0] res_r;

  logic               launch_s;
  logic [WIDTH:0]     shift_s;
  logic [WIDTH:0]     trial_s;
  logic [WIDTH-1:0]   rem_nxt_s;
  logic [WIDTH-1:0]   quo_nxt_s;

  function automatic logic [WIDTH-1:0] neg_f(input logic [WIDTH-1:0] v);
    neg_f = (~v) + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [WIDTH-1:0] abs_f(input logic [WIDTH-1:0] v, input logic sgn);
    if (sgn && v[WIDTH-1]) begin
      abs_f = neg_f(v);
    end else begin
      abs_f = v;
    end
  endfunction

  assign launch_s = bus.div_start & ~bus.div_cancel;

  // One restoring step: quo_r doubles as the dividend shift register feeding rem_r.
  always_comb begin
    shift_s = {rem_r, quo_r[WIDTH-1]};
    trial_s = shift_s - {1'b0, dvs_r};
    if (trial_s[WIDTH]) begin
      rem_nxt_s = shift_s[WIDTH-1:0];
      quo_nxt_s = {quo_r[WIDTH-2:0], 1'b0};
    end else begin
      rem_nxt_s = trial_s[WIDTH-1:0];
      quo_nxt_s = {quo_r[WIDTH-2:0], 1'b1};
    end
  end

  // Sequencer FSM with registered busy/done/result.
  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      rem_r   <= '0;
      quo_r   <= '0;
      dvs_r   <= '0;
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      res_r   <= '0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (launch_s) begin
            state_r <= (bus.div_opb == '0) ? DIVZERO : RUN;
            busy_r  <= 1'b1;
            cnt_r   <= '0;
            rem_r   <= '0;
            quo_r   <= abs_f(bus.div_opa, bus.div_signed);
            dvs_r   <= abs_f(bus.div_opb, bus.div_signed);
            neg_q_r <= bus.div_signed & (bus.div_opa[WIDTH-1] ^ bus.div_opb[WIDTH-1]);
            neg_r_r <= bus.div_signed & bus.div_opa[WIDTH-1];
          end else begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        DIVZERO: begin
          if (bus.div_cancel) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end else begin
            state_r <= DONE;
            done_r  <= 1'b1;
            res_r   <= {quo_r, {WIDTH{1'b1}}};
          end
        end
        RUN: begin
          if (bus.div_cancel) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end else begin
            rem_r <= rem_nxt_s;
            quo_r <= quo_nxt_s;
            cnt_r <= cnt_r + ONE_CNT;
            if (cnt_r == LAST_CNT) begin
              // Sign fixup also covers MIN/-1: negating 0x80..0 yields itself.
              state_r <= DONE;
              done_r  <= 1'b1;
              res_r   <= {neg_r_r ? neg_f(rem_nxt_s) : rem_nxt_s,
                          neg_q_r ? neg_f(quo_nxt_s) : quo_nxt_s};
            end else begin
              state_r <= RUN;
            end
          end
        end
        DONE: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.div_busy     = busy_r;
  assign bus.div_done     = done_r;
  assign bus.div_hilowe   = done_r;
  assign bus.div_res      = res_r;
  assign bus.div_stallreq = ((state_r == IDLE) & launch_s) | (state_r == DIVZERO) | (state_r == RUN);
endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: expected results are queued at launch and
// compared when div_done pulses; latency, stall and cancel/reset behaviour checked inline.
module tb_div_seq;
  logic cpu_clk_50M;
  logic cpu_rst;
  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  logic [63:0] sb_q[$];
  logic [63:0] last_res;

  div_if #(.WIDTH(32)) bus ();

  div_seq #(.WIDTH(32)) dut (
    .cpu_clk_50M(cpu_clk_50M),
    .cpu_rst(cpu_rst),
    .bus(bus.slave)
  );

  initial cpu_clk_50M = 1'b0;
  always #10 cpu_clk_50M = ~cpu_clk_50M;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] aa;
    int sa, sd;
    aa = (sgn && a[31]) ? (32'h0 - a) : a;
    if (b == 32'h0) return {aa, 32'hFFFF_FFFF};
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
    if (!sgn) return {a % b, a / b};
    sa = $signed(a);
    sd = $signed(b);
    return {32'(sa % sd), 32'(sa / sd)};
  endfunction

  // Scoreboard: every done pulse must match the oldest queued expectation.
  always @(negedge cpu_clk_50M) begin
    if (!cpu_rst && bus.div_done) begin
      done_cnt++;
      chk("hilowe", {63'h0, bus.div_hilowe}, 64'h1);
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 64'h1, 64'h0);
      end else begin
        chk("div_res", bus.div_res, sb_q.pop_front());
      end
    end
  end

  task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input int exp_lat);
    int lat;
    logic stall_ok;
    @(posedge cpu_clk_50M); #1;
    bus.div_start = 1'b1;
    bus.div_signed = sgn;
    bus.div_opa = a;
    bus.div_opb = b;
    sb_q.push_back(exp);
    @(negedge cpu_clk_50M);
    chk("stall_c0", {63'h0, bus.div_stallreq}, 64'h1);
    @(posedge cpu_clk_50M); #1;
    bus.div_start = 1'b0;
    bus.div_opa = ~a;
    bus.div_opb = 32'h0;
    lat = 0;
    stall_ok = 1'b1;
    do begin
      @(negedge cpu_clk_50M);
      lat++;
      if (!bus.div_done) stall_ok &= bus.div_stallreq & bus.div_busy;
    end while (!bus.div_done && lat < 200);
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("stall_busy_run", {63'h0, stall_ok}, 64'h1);
    chk("stall_at_done", {63'h0, bus.div_stallreq}, 64'h0);
    @(negedge cpu_clk_50M);
    chk("done_one_cycle", {63'h0, bus.div_done}, 64'h0);
    chk("idle_after_done", {63'h0, bus.div_busy}, 64'h0);
    chk("res_hold", bus.div_res, exp);
    last_res = exp;
  endtask

  initial begin
    int dc;
    logic [31:0] ra, rb;
    logic rs;
    cpu_rst = 1'b1;
    bus.div_start = 1'b0;
    bus.div_signed = 1'b0;
    bus.div_opa = 32'h0;
    bus.div_opb = 32'h0;
    bus.div_cancel = 1'b0;
    last_res = 64'h0;
    #25;
    chk("rst_busy", {63'h0, bus.div_busy}, 64'h0);
    chk("rst_done", {63'h0, bus.div_done}, 64'h0);
    chk("rst_hilowe", {63'h0, bus.div_hilowe}, 64'h0);
    chk("rst_res", bus.div_res, 64'h0);
    chk("rst_stall", {63'h0, bus.div_stallreq}, 64'h0);
    cpu_rst = 1'b0;

    run_op(1'b0, 32'd7, 32'd2, 64'h00000001_00000003, 33);
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 33);
    run_op(1'b1, 32'd7, 32'hFFFF_FFFE, 64'h00000001_FFFFFFFD, 33);
    run_op(1'b0, 32'h0000_1234, 32'h0, 64'h00001234_FFFFFFFF, 2);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h00000000_80000000, 33);
    run_op(1'b0, 32'hFFFF_FFFF, 32'd1, 64'h00000000_FFFFFFFF, 33);
    run_op(1'b1, 32'hFFFF_FFF0, 32'h0, 64'h00000010_FFFFFFFF, 2);

    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 30);
      if (rb == 32'h0) rb = 32'd3;
      rs = i[0];
      run_op(rs, ra, rb, model(rs, ra, rb), 33);
    end

    // Cancel mid-run: no pulse, result untouched, then a clean 100/7.
    dc = done_cnt;
    @(posedge cpu_clk_50M); #1;
    bus.div_start = 1'b1; bus.div_signed = 1'b0; bus.div_opa = 32'd55; bus.div_opb = 32'd3;
    @(posedge cpu_clk_50M); #1;
    bus.div_start = 1'b0;
    repeat (9) @(posedge cpu_clk_50M);
    #1 bus.div_cancel = 1'b1;
    @(posedge cpu_clk_50M); #1;
    bus.div_cancel = 1'b0;
    @(negedge cpu_clk_50M);
    chk("cancel_busy", {63'h0, bus.div_busy}, 64'h0);
    chk("cancel_stall", {63'h0, bus.div_stallreq}, 64'h0);
    chk("cancel_res", bus.div_res, last_res);
    repeat (40) @(posedge cpu_clk_50M);
    chk("cancel_no_done", 64'(done_cnt), 64'(dc));
    run_op(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33);

    // Start and cancel together in IDLE.
    @(posedge cpu_clk_50M); #1;
    bus.div_start = 1'b1; bus.div_cancel = 1'b1; bus.div_opb = 32'd5;
    @(negedge cpu_clk_50M);
    chk("sc_stall", {63'h0, bus.div_stallreq}, 64'h0);
    @(posedge cpu_clk_50M); #1;
    bus.div_start = 1'b0; bus.div_cancel = 1'b0;
    @(negedge cpu_clk_50M);
    chk("sc_busy", {63'h0, bus.div_busy}, 64'h0);

    // Asynchronous reset mid-run.
    dc = done_cnt;
    @(posedge cpu_clk_50M); #1;
    bus.div_start = 1'b1; bus.div_signed = 1'b0; bus.div_opa = 32'd7; bus.div_opb = 32'd2;
    @(posedge cpu_clk_50M); #1;
    bus.div_start = 1'b0;
    repeat (5) @(posedge cpu_clk_50M);
    #3 cpu_rst = 1'b1;
    #1;
    chk("arst_busy", {63'h0, bus.div_busy}, 64'h0);
    chk("arst_res", bus.div_res, 64'h0);
    chk("arst_stall", {63'h0, bus.div_stallreq}, 64'h0);
    #5 cpu_rst = 1'b0;
    repeat (40) @(posedge cpu_clk_50M);
    chk("arst_no_done", 64'(done_cnt), 64'(dc));
    chk("sb_empty", 64'(sb_q.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
